// File: rtl/sp_pkg.sv
// Shared defaults and state encoding for the setpoint ramp generator.
package sp_pkg;

  localparam int WIDTH_DEF  = 20;
  localparam int STEP_W_DEF = 12;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/sp_tick.sv
// Update-interval divider: issues one tick every i_div+1 enabled, unheld cycles.
module sp_tick
  import sp_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_hold,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_run;

  assign w_run  = i_en && !i_hold && !i_clr;
  assign o_tick = w_run && (r_cnt == i_div);

  // A live divide value below the count lets the counter wrap through zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_run) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sp_ramp.sv
// Setpoint ramp generator: slews SP_out toward a loaded target by a fixed step
// once per divided interval, never overshooting.
module sp_ramp
  import sp_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] TGT_in,
  input  logic                    TGT_load,
  input  logic [STEP_W-1:0]       STEP_in,
  input  logic [DIV_W-1:0]        DIV_in,
  input  logic                    HOLD_in,
  output logic signed [WIDTH-1:0] SP_out,
  output logic                    SP_strb,
  output logic                    AT_tgt,
  output logic                    BUSY
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [WIDTH-1:0]  r_sp;
  logic signed [WIDTH-1:0]  w_sp_next;
  logic signed [WIDTH-1:0]  r_tgt;
  logic signed [WIDTH-1:0]  w_tgt_next;
  logic [STEP_W-1:0]        r_step;
  logic [STEP_W-1:0]        w_step_next;
  logic                     r_strb;
  logic                     w_ramping;
  logic                     w_tick;
  logic signed [WIDTH:0]    w_sp_ext;
  logic signed [WIDTH:0]    w_tgt_ext;
  logic signed [WIDTH:0]    w_step_ext;
  logic signed [WIDTH:0]    w_up_sum;
  logic signed [WIDTH:0]    w_dn_diff;

  assign w_ramping = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);

  sp_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (TGT_load),
    .i_en   (w_ramping),
    .i_hold (HOLD_in),
    .i_div  (DIV_in),
    .o_tick (w_tick)
  );

  // One extra bit of headroom so the step cannot wrap past either rail.
  assign w_sp_ext   = {r_sp[WIDTH-1], r_sp};
  assign w_tgt_ext  = {r_tgt[WIDTH-1], r_tgt};
  assign w_step_ext = {{(WIDTH+1-STEP_W){1'b0}}, r_step};
  assign w_up_sum   = w_sp_ext + w_step_ext;
  assign w_dn_diff  = w_sp_ext - w_step_ext;

  always_comb begin
    w_state_next = r_state;
    w_sp_next    = r_sp;
    w_tgt_next   = r_tgt;
    w_step_next  = r_step;
    if (TGT_load) begin
      w_tgt_next  = TGT_in;
      w_step_next = (STEP_in == '0) ? STEP_W'(1) : STEP_in;
      if (TGT_in > r_sp) begin
        w_state_next = RAMP_UP;
      end else if (TGT_in < r_sp) begin
        w_state_next = RAMP_DOWN;
      end else begin
        w_state_next = DONE;
      end
    end else if (w_tick) begin
      case (r_state)
        RAMP_UP: begin
          if (w_up_sum >= w_tgt_ext) begin
            w_sp_next    = r_tgt;
            w_state_next = DONE;
          end else begin
            w_sp_next = w_up_sum[WIDTH-1:0];
          end
        end
        RAMP_DOWN: begin
          if (w_dn_diff <= w_tgt_ext) begin
            w_sp_next    = r_tgt;
            w_state_next = DONE;
          end else begin
            w_sp_next = w_dn_diff[WIDTH-1:0];
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sp    <= '0;
      r_tgt   <= '0;
      r_step  <= STEP_W'(1);
      r_strb  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sp    <= w_sp_next;
      r_tgt   <= w_tgt_next;
      r_step  <= w_step_next;
      r_strb  <= (w_sp_next != r_sp);
    end
  end

  assign SP_out  = r_sp;
  assign SP_strb = r_strb;
  assign AT_tgt  = (r_state == IDLE) || (r_state == DONE);
  assign BUSY    = w_ramping;

endmodule

// File: tb/tb_sp_ramp.sv
// Self-checking bench for sp_ramp: a cycle model pushes expected outputs to a
// scoreboard queue, compared one edge later; directed checks cover key scenarios.
module tb_sp_ramp;

  localparam int WIDTH  = 20;
  localparam int STEP_W = 12;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic signed [WIDTH-1:0] TGT_in;
  logic                    TGT_load;
  logic [STEP_W-1:0]       STEP_in;
  logic [DIV_W-1:0]        DIV_in;
  logic                    HOLD_in;
  logic signed [WIDTH-1:0] SP_out;
  logic                    SP_strb;
  logic                    AT_tgt;
  logic                    BUSY;

  always #5 clk = ~clk;

  sp_ramp #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .TGT_in   (TGT_in),
    .TGT_load (TGT_load),
    .STEP_in  (STEP_in),
    .DIV_in   (DIV_in),
    .HOLD_in  (HOLD_in),
    .SP_out   (SP_out),
    .SP_strb  (SP_strb),
    .AT_tgt   (AT_tgt),
    .BUSY     (BUSY)
  );

  typedef struct {
    int sp;
    int strb;
    int at;
    int busy;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: 0 idle, 1 up, 2 down, 3 done
  int m_sp, m_tgt, m_step, m_cnt, m_st;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int   old_sp;
    int   s;
    exp_t e;
    old_sp = m_sp;
    if (!rst_n) begin
      m_sp = 0; m_tgt = 0; m_step = 1; m_cnt = 0; m_st = 0;
    end else if (TGT_load) begin
      m_tgt  = int'(TGT_in);
      m_step = (STEP_in == 0) ? 1 : int'(STEP_in);
      m_cnt  = 0;
      m_st   = (m_tgt > m_sp) ? 1 : (m_tgt < m_sp) ? 2 : 3;
    end else if ((m_st == 1 || m_st == 2) && !HOLD_in) begin
      if (m_cnt == int'(DIV_in)) begin
        m_cnt = 0;
        if (m_st == 1) begin
          s = m_sp + m_step;
          if (s >= m_tgt) begin s = m_tgt; m_st = 3; end
        end else begin
          s = m_sp - m_step;
          if (s <= m_tgt) begin s = m_tgt; m_st = 3; end
        end
        m_sp = s;
      end else begin
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    e.sp   = m_sp;
    e.strb = (rst_n && (m_sp != old_sp)) ? 1 : 0;
    e.at   = (m_st == 0 || m_st == 3) ? 1 : 0;
    e.busy = (m_st == 1 || m_st == 2) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_sp",   int'(SP_out),  e.sp);
    chk("sb_strb", int'(SP_strb), e.strb);
    chk("sb_at",   int'(AT_tgt),  e.at);
    chk("sb_busy", int'(BUSY),    e.busy);
  endtask

  task automatic load(input int tgt, input int stp, input int dv);
    TGT_in   = WIDTH'(tgt);
    STEP_in  = STEP_W'(stp);
    DIV_in   = DIV_W'(dv);
    TGT_load = 1'b1;
    cyc();
    TGT_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int seq_a[4];
    int seq_b[4];
    seq_a = '{30, 60, 90, 100};
    seq_b = '{60, 20, -20, -50};
    rst_n = 1'b0; TGT_in = '0; TGT_load = 1'b0; STEP_in = '0; DIV_in = '0; HOLD_in = 1'b0;

    // Reset state
    do_reset();
    chk("rst_sp", int'(SP_out), 0);
    chk("rst_at", int'(AT_tgt), 1);
    chk("rst_busy", int'(BUSY), 0);

    // 0 -> 100, step 30, every edge
    load(100, 30, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("up_seq", int'(SP_out), seq_a[i]);
      chk("up_strb", int'(SP_strb), 1);
    end
    chk("up_at", int'(AT_tgt), 1);

    // 100 -> -50, step 40, every 4th edge
    load(-50, 40, 3);
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i % 4 == 3) chk("dn_seq", int'(SP_out), seq_b[i / 4]);
    end
    chk("dn_busy", int'(BUSY), 0);

    // Full-scale rise and fall without wrap
    do_reset();
    load(32'h7FFFF, 12'hFFF, 0);
    for (int i = 0; i < 400 && BUSY; i++) begin
      prev = int'(SP_out);
      cyc();
      chk("rise_mono", (int'(SP_out) > prev) ? 1 : 0, 1);
      chk("rise_pos", (SP_out >= 0) ? 1 : 0, 1);
    end
    chk("rise_end", int'(SP_out), 524287);
    load(-524288, 12'hFFF, 0);
    for (int i = 0; i < 400 && BUSY; i++) begin
      prev = int'(SP_out);
      cyc();
      chk("fall_mono", (int'(SP_out) < prev) ? 1 : 0, 1);
    end
    chk("fall_end", int'(SP_out), -524288);

    // Hold freezes at 200 and resumes one edge after release
    do_reset();
    load(1000, 10, 0);
    for (int i = 0; i < 20; i++) cyc();
    chk("hold_pre", int'(SP_out), 200);
    HOLD_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_sp", int'(SP_out), 200);
    end
    HOLD_in = 1'b0;
    cyc();
    chk("hold_rel", int'(SP_out), 210);

    // Retarget on a tick edge: no step that edge
    do_reset();
    load(1000, 10, 0);
    for (int i = 0; i < 30; i++) cyc();
    chk("rt_pre", int'(SP_out), 300);
    load(500, 10, 0);
    chk("rt_nostep", int'(SP_out), 300);
    chk("rt_busy", int'(BUSY), 1);
    cyc();
    chk("rt_next", int'(SP_out), 310);

    // Mid-ramp reset at -70, then step-0 load steps by 1
    do_reset();
    load(-100, 10, 0);
    for (int i = 0; i < 7; i++) cyc();
    chk("mr_pre", int'(SP_out), -70);
    do_reset();
    chk("mr_sp", int'(SP_out), 0);
    chk("mr_at", int'(AT_tgt), 1);
    chk("mr_busy", int'(BUSY), 0);
    load(5, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s0_seq", int'(SP_out), i + 1);
    end
    chk("s0_at", int'(AT_tgt), 1);

    // Load while held: state changes, no stepping until release
    HOLD_in = 1'b1;
    load(50, 5, 0);
    chk("hl_busy", int'(BUSY), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hl_sp", int'(SP_out), 5);
    end
    HOLD_in = 1'b0;
    cyc();
    chk("hl_rel", int'(SP_out), 10);

    // Lowering DIV_in below the count wraps the counter rather than locking up
    do_reset();
    load(1000, 1, 10);
    for (int i = 0; i < 6; i++) cyc();
    DIV_in = DIV_W'(2);
    for (int i = 0; i < 300; i++) cyc();
    chk("wrap_live", (SP_out > 0) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
